mult_div_unit: RTL

//  Multicycle signed MULT/DIV responder for the control unit's HI/LO handshake.

---
 rtl/mult_div_pkg.sv | 22 ++
 rtl/mult_div_unit_booth_step.sv | 35 +++
 rtl/mult_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle signed MULT/DIV unit: FSM state
// encoding, default operand width, counter width and Booth pair codes.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    // Booth recoding of {q0, q-1}: 00/11 hold, 01 add, 10 subtract
    localparam logic [1:0] BOOTH_HOLD0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD   = 2'b01;
    localparam logic [1:0] BOOTH_SUB   = 2'b10;
    localparam logic [1:0] BOOTH_HOLD1 = 2'b11;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth iteration: add/subtract the multiplicand into the upper
// half of the {P_hi, P_lo, q-1} accumulator, then shift the whole thing right
// arithmetically. The add is done one bit wider so the most negative
// multiplicand cannot overflow the partial product.
import mult_div_pkg::*;

module booth_step #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] mcand,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0] hi_ext_s;
    logic [WIDTH:0] mc_ext_s;
    logic [WIDTH:0] sum_s;

    assign hi_ext_s = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    assign mc_ext_s = {mcand[WIDTH-1], mcand};

    // Choose hold/add/subtract from the current Booth pair
    always_comb begin
        sum_s = hi_ext_s;
        case (acc[1:0])
            BOOTH_ADD: sum_s = hi_ext_s + mc_ext_s;
            BOOTH_SUB: sum_s = hi_ext_s - mc_ext_s;
            default:   sum_s = hi_ext_s;
        endcase
    end

    // Arithmetic shift right: sum[W:1] -> P_hi, sum[0] -> P_lo msb, P_lo[0] -> q-1
    assign acc_next = {sum_s, acc[WIDTH:1]};

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, on magnitudes)
// responder for the HI/LO handshake. hi/lo change only when done pulses.
// Optional feature macro: MD_DIVZERO_EXC_EN -- divide by zero short-circuits
// to done with div_zero=1 and leaves hi/lo untouched.
import mult_div_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef MD_DIVZERO_EXC_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               op_div_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH:0]   acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH:0]     divisor_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [2*WIDTH:0]   booth_next_s;
    logic [WIDTH:0]     shifted_s;
    logic               ge_s;
    logic [WIDTH-1:0]   rem_next_s;
`ifdef MD_DIVZERO_EXC_EN
    logic               dz_r;
    logic               div_zero_r;
`endif

    // Two's complement negate when neg is set
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_booth_step (
        .acc      (acc_r),
        .mcand    (mcand_r),
        .acc_next (booth_next_s)
    );

    // Restoring divider step: shift in next dividend bit, subtract if it fits.
    // A fitting difference is below the divisor, so W bits hold it exactly.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        ge_s      = (shifted_s >= divisor_r);
        if (ge_s) begin
            rem_next_s = shifted_s[WIDTH-1:0] - divisor_r[WIDTH-1:0];
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            op_div_r  <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH+1){1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            divisor_r <= {(WIDTH+1){1'b0}};
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
`ifdef MD_DIVZERO_EXC_EN
            dz_r       <= 1'b0;
            div_zero_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MD_DIVZERO_EXC_EN
            div_zero_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (start_mult) begin
                        acc_r    <= {{WIDTH{1'b0}}, b, 1'b0};
                        mcand_r  <= a;
                        cnt_r    <= {CNT_W{1'b0}};
                        busy_r   <= 1'b1;
                        op_div_r <= 1'b0;
`ifdef MD_DIVZERO_EXC_EN
                        dz_r     <= 1'b0;
`endif
                        state_r  <= ST_MULT;
                    end else if (start_div) begin
                        sign_a_r  <= a[WIDTH-1];
                        sign_b_r  <= b[WIDTH-1];
                        quo_r     <= cond_neg(a, a[WIDTH-1]);
                        rem_r     <= {WIDTH{1'b0}};
                        divisor_r <= {1'b0, cond_neg(b, b[WIDTH-1])};
                        cnt_r     <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        op_div_r  <= 1'b1;
`ifdef MD_DIVZERO_EXC_EN
                        if (b == {WIDTH{1'b0}}) begin
                            dz_r    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            dz_r    <= 1'b0;
                            state_r <= ST_DIV;
                        end
`else
                        state_r   <= ST_DIV;
`endif
                    end
                end
                ST_MULT: begin
                    acc_r <= booth_next_s;
                    if (cnt_r == CNT_W'(WIDTH-1)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[WIDTH-2:0], ge_s};
                    if (cnt_r == CNT_W'(WIDTH-1)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    // Truncate toward zero: quotient sign a^b, remainder sign of a
                    quo_r   <= cond_neg(quo_r, sign_a_r ^ sign_b_r);
                    rem_r   <= cond_neg(rem_r, sign_a_r);
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
`ifdef MD_DIVZERO_EXC_EN
                    if (dz_r) begin
                        div_zero_r <= 1'b1;
                    end else
`endif
                    if (op_div_r) begin
                        hi_r <= rem_r;
                        lo_r <= quo_r;
                    end else begin
                        hi_r <= acc_r[2*WIDTH:WIDTH+1];
                        lo_r <= acc_r[WIDTH:1];
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
`ifdef MD_DIVZERO_EXC_EN
    assign div_zero = div_zero_r;
`endif

endmodule
